// File: rtl/uart_pkg.sv
// uart_pkg: register map, status bit positions and RX state encoding shared by
// the UART controller and its receiver.
`default_nettype none

package uart_pkg;

  localparam int WORD_W      = 32;
  localparam int UART_ADDR_W = 2;

  localparam logic [UART_ADDR_W-1:0] UART_ADDR_STATUS = 2'd0;
  localparam logic [UART_ADDR_W-1:0] UART_ADDR_DATA   = 2'd1;

  localparam int STAT_RX_DONE = 0;
  localparam int STAT_TX_DONE = 1;
  localparam int STAT_RX_BUSY = 2;
  localparam int STAT_TX_BUSY = 3;
  localparam int STAT_LOOP    = 4;

  localparam int UART_DIV_RATE = 868;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx.sv
// uart_rx: two-flop synchroniser and 8N1 receive state machine.
// rx_end pulses for one cycle when a frame with a valid stop bit completes.
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV_RATE = UART_DIV_RATE
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_end,
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(DIV_RATE);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DIV_RATE - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV_RATE / 2 - 1);

  logic             sync1, sync2, rx_prev;
  rx_state_t        state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state <= RX_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    rx_end     = 1'b0;
    case (state)
      RX_IDLE:  if (rx_prev && !sync2) state_next = RX_START;
      RX_START: if (cnt == '0) state_next = sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt == '0 && bit_cnt == 3'd7) state_next = RX_STOP;
      RX_STOP: begin
        if (cnt == '0) begin
          state_next = RX_IDLE;
          rx_end     = sync2;
        end
      end
      default:  state_next = RX_IDLE;
    endcase
  end

  // IDLE preloads the half-bit delay so START samples mid start bit
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cnt     <= '0;
      bit_cnt <= 3'd0;
      shift   <= 8'd0;
      rx_data <= 8'd0;
    end else begin
      if (state == RX_IDLE) begin
        cnt     <= HALF;
        bit_cnt <= 3'd0;
      end else if (cnt == '0) begin
        cnt <= FULL;
        if (state == RX_DATA) begin
          shift   <= {sync2, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
      if (rx_end) rx_data <= shift;
    end
  end

  assign rx_busy = (state != RX_IDLE);

endmodule

`default_nettype wire

// File: rtl/uart_ctrl.sv
// uart_ctrl: memory-mapped 8N1 UART (STATUS/DATA registers, TX engine, IRQs).
// Optional feature macro: UART_LOOPBACK_EN (STATUS bit4 internal loopback).
`default_nettype none

module uart_ctrl
  import uart_pkg::*;
#(
  parameter int DIV_RATE = UART_DIV_RATE
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   CS_,
  input  logic                   As_,
  input  logic                   RW,
  input  logic [UART_ADDR_W-1:0] Addr,
  input  logic [WORD_W-1:0]      WrData,
  output logic [WORD_W-1:0]      RdData,
  output logic                   Rdy_,
  output logic                   IRQRx,
  output logic                   IRQTx,
  input  logic                   RX,
  output logic                   TX
);

  localparam int CNT_W = $clog2(DIV_RATE);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DIV_RATE - 1);

  logic             access, wr_status, tx_start, tx_end;
  logic             rx_done, tx_done, loop, tx_line, rx_in;
  logic             rx_end, rx_busy, tx_busy;
  logic [7:0]       rx_data;
  logic [9:0]       tx_shift;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bit;
  logic [WORD_W-1:0] rd_mux;
  logic             unused_wrdata;

  assign access    = !CS_ && !As_;
  assign wr_status = access && !RW && (Addr == UART_ADDR_STATUS);
  assign tx_start  = access && !RW && (Addr == UART_ADDR_DATA) && !tx_busy;
  assign tx_end    = tx_busy && (tx_cnt == '0) && (tx_bit == 4'd9);
  assign unused_wrdata = ^{WrData[WORD_W-1:8], WrData[STAT_LOOP]};

`ifdef UART_LOOPBACK_EN
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)        loop <= 1'b0;
    else if (wr_status) loop <= WrData[STAT_LOOP];
  end
`else
  assign loop = 1'b0;
`endif

  // Frame shifts out LSB first; ones fill in behind so the line idles high
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      tx_shift <= '1;
      tx_cnt   <= '0;
      tx_bit   <= 4'd0;
      tx_busy  <= 1'b0;
    end else if (tx_start) begin
      tx_shift <= {1'b1, WrData[7:0], 1'b0};
      tx_cnt   <= FULL;
      tx_bit   <= 4'd0;
      tx_busy  <= 1'b1;
    end else if (tx_busy) begin
      if (tx_cnt == '0) begin
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_cnt   <= FULL;
        tx_bit   <= tx_bit + 4'd1;
        if (tx_bit == 4'd9) tx_busy <= 1'b0;
      end else begin
        tx_cnt <= tx_cnt - 1'b1;
      end
    end
  end

  assign tx_line = tx_shift[0];
  assign TX      = loop ? 1'b1 : tx_line;
  assign rx_in   = loop ? tx_line : RX;

  uart_rx #(.DIV_RATE(DIV_RATE)) u_rx (
    .clk     (clk),
    .reset_  (reset_),
    .rx      (rx_in),
    .rx_data (rx_data),
    .rx_end  (rx_end),
    .rx_busy (rx_busy)
  );

  // Hardware set takes priority over a simultaneous software write
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rx_done <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      if (rx_end)         rx_done <= 1'b1;
      else if (wr_status) rx_done <= WrData[STAT_RX_DONE];
      if (tx_end)         tx_done <= 1'b1;
      else if (wr_status) tx_done <= WrData[STAT_TX_DONE];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (Addr)
      UART_ADDR_STATUS: begin
        rd_mux[STAT_RX_DONE] = rx_done;
        rd_mux[STAT_TX_DONE] = tx_done;
        rd_mux[STAT_RX_BUSY] = rx_busy;
        rd_mux[STAT_TX_BUSY] = tx_busy;
        rd_mux[STAT_LOOP]    = loop;
      end
      UART_ADDR_DATA: rd_mux[7:0] = rx_data;
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      Rdy_   <= 1'b1;
      RdData <= '0;
    end else begin
      Rdy_   <= !access;
      RdData <= (access && RW) ? rd_mux : '0;
    end
  end

  assign IRQRx = rx_done;
  assign IRQTx = tx_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed self-checking bench for uart_ctrl with DIV_RATE = 16.
`default_nettype none

module tb_uart_ctrl;

  localparam int DIV = 16;

  logic        clk    = 1'b0;
  logic        reset_ = 1'b0;
  logic        CS_    = 1'b1;
  logic        As_    = 1'b1;
  logic        RW     = 1'b1;
  logic [1:0]  Addr   = 2'd0;
  logic [31:0] WrData = 32'd0;
  logic        RX     = 1'b1;
  logic [31:0] RdData;
  logic        Rdy_, IRQRx, IRQTx, TX;

  int n_checks = 0;
  int n_fail   = 0;

  uart_ctrl #(.DIV_RATE(DIV)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .CS_    (CS_),
    .As_    (As_),
    .RW     (RW),
    .Addr   (Addr),
    .WrData (WrData),
    .RdData (RdData),
    .Rdy_   (Rdy_),
    .IRQRx  (IRQRx),
    .IRQTx  (IRQTx),
    .RX     (RX),
    .TX     (TX)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end 1 time unit after a rising edge
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    CS_ = 1'b0; As_ = 1'b0; RW = 1'b0; Addr = a; WrData = d;
    @(posedge clk); #1;
    check("wr_rdy", Rdy_, 0);
    check("wr_rddata", RdData, 0);
    CS_ = 1'b1; As_ = 1'b1; RW = 1'b1;
  endtask

  task automatic bus_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    CS_ = 1'b0; As_ = 1'b0; RW = 1'b1; Addr = a;
    @(posedge clk); #1;
    check("rd_rdy", Rdy_, 0);
    check(tag, RdData, exp);
    CS_ = 1'b1; As_ = 1'b1;
  endtask

  // Checks each TX bit mid-period and IRQTx around the frame end.
  // disturb adds a DATA write at cycle 50 and a STATUS read at cycle 100.
  task automatic tx_frame(input logic [7:0] b, input bit disturb);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int cyc = 1; cyc <= 10 * DIV; cyc++) begin
      @(posedge clk); #1;
      if (disturb && cyc == 50) begin
        check("busy_wr_rdy", Rdy_, 0);
        CS_ = 1'b1; As_ = 1'b1; RW = 1'b1;
      end
      if (disturb && cyc == 100) begin
        check("status_midframe", RdData, 32'h8);
        CS_ = 1'b1; As_ = 1'b1;
      end
      if (cyc % DIV == DIV / 2) check($sformatf("tx_bit%0d", cyc / DIV), TX, frame[cyc / DIV]);
      if (cyc == 10 * DIV - 1) check("irqtx_early", IRQTx, 0);
      if (cyc == 10 * DIV)     check("irqtx_end", IRQTx, 1);
      if (disturb && cyc == 49) begin
        CS_ = 1'b0; As_ = 1'b0; RW = 1'b0; Addr = 2'd1; WrData = 32'h0;
      end
      if (disturb && cyc == 99) begin
        CS_ = 1'b0; As_ = 1'b0; RW = 1'b1; Addr = 2'd0;
      end
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = frame[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
    RX = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", TX, 1);
    check("rst_rdy", Rdy_, 1);
    check("rst_rddata", RdData, 0);
    check("rst_irqrx", IRQRx, 0);
    check("rst_irqtx", IRQTx, 0);
    reset_ = 1'b1;
    @(posedge clk); #1;
    bus_read("rst_status", 2'd0, 32'h0);
    bus_read("rst_data", 2'd1, 32'h0);
    bus_read("addr2", 2'd2, 32'h0);

    // Transmit 0xA5 with a disturbing write mid-frame
    bus_write(2'd1, 32'h0000_00A5);
    tx_frame(8'hA5, 1'b1);
    bus_read("status_txdone", 2'd0, 32'h2);
    bus_write(2'd0, 32'h0);
    check("irqtx_clear", IRQTx, 0);

    // Receive 0x3C
    send_rx(8'h3C, 1'b1);
    check("irqrx_set", IRQRx, 1);
    bus_read("status_rxdone", 2'd0, 32'h1);
    bus_read("data_3c", 2'd1, 32'h3C);
    bus_write(2'd0, 32'h0);
    check("irqrx_clear", IRQRx, 0);

    // Start-bit glitch, then a frame with a bad stop bit
    RX = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    RX = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send_rx(8'h55, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("glitch_irqrx", IRQRx, 0);
    bus_read("glitch_status", 2'd0, 32'h0);
    bus_read("glitch_data", 2'd1, 32'h3C);

    // Reset during a frame
    bus_write(2'd1, 32'h0);
    repeat (38) @(posedge clk);
    #1;
    check("tx_before_rst", TX, 0);
    @(posedge clk); #1;
    reset_ = 1'b0;
    #1;
    check("tx_async_rst", TX, 1);
    check("rst2_rdy", Rdy_, 1);
    @(negedge clk);
    reset_ = 1'b1;
    @(posedge clk); #1;
    bus_read("rst2_status", 2'd0, 32'h0);
    bus_write(2'd1, 32'h0000_000F);
    tx_frame(8'h0F, 1'b0);
    bus_write(2'd0, 32'h0);

`ifdef UART_LOOPBACK_EN
    begin
      bit saw_low;
      saw_low = 1'b0;
      bus_write(2'd0, 32'h10);
      bus_read("loop_status", 2'd0, 32'h10);
      bus_write(2'd1, 32'h7E);
      for (int c = 0; c < 11 * DIV; c++) begin
        if (TX !== 1'b1) saw_low = 1'b1;
        @(posedge clk); #1;
      end
      check("loop_tx_high", {31'd0, saw_low}, 0);
      check("loop_irqrx", IRQRx, 1);
      bus_read("loop_status_done", 2'd0, 32'h13);
      bus_read("loop_data", 2'd1, 32'h7E);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_ctrl.md
# uart_ctrl

Memory-mapped 8N1 UART controller and bus slave on slave port S5, alongside the ROM (S0) and GPIO (S4). It serialises bytes written by the CPU onto a TX pin and deserialises an asynchronous RX pin into a readable data register. It raises level interrupts on transmit and receive completion for the CPU IRQ bus.

## Interface
- DIV_RATE, 868: clock cycles per bit period (100 MHz / 115200). Legal range is ≥ 4.
- clk  in  1  system clock (one clock domain)
- reset_  in  1  asynchronous, active-low reset
- CS_  in  1  chip select from bus decoder, active low
- As_  in  1  address strobe, active low
- RW  in  1  1 = read, 0 = write
- Addr  in  2  word offset within the UART window
- WrData  in  32  write data
- RdData  out  32  read data
- Rdy_  out  1  access acknowledge, active low
- IRQRx  out  1  receive-complete interrupt (level)
- IRQTx  out  1  transmit-complete interrupt (level)
- RX  in  1  serial input (asynchronous)
- TX  out  1  serial output

## Operation
- Register map:
  - Addr 0, STATUS:
    - bit0 RxDone (R/W)
    - bit1 TxDone (R/W)
    - bit2 RxBusy (RO)
    - bit3 TxBusy (RO)
    - bit4 Loop (R/W, see Configuration)
    - other bits read 0
  - Addr 1, DATA: a write loads WrData[7:0] for transmit; a read returns the last received byte, zero-extended.
  - Addr 2 and 3: read 0; writes are ignored.
- STATUS write: bits 0, 1 and 4 take WrData values directly. Software clears a flag by writing 0.
- DATA write while TxBusy = 1: ignored. The frame in flight is unaffected and no flag is set.
- TX frame:
  - Idle level is 1.
  - Frame is: start 0, then D0..D7 LSB first, then stop 1. Each bit lasts exactly DIV_RATE cycles, 10·DIV_RATE cycles in total.
  - TxBusy is 1 for the whole frame.
  - TxDone sets on the cycle TxBusy falls.
- RX:
  - RX passes through a 2-flop synchroniser.
  - State machine states are IDLE, START, DATA, STOP.
  - IDLE → START on a synchronised 1→0 transition.
  - START: wait DIV_RATE/2 cycles (integer division), then sample. If the sample is 0, go to DATA; otherwise treat it as a glitch and return to IDLE.
  - DATA: sample 8 bits at DIV_RATE intervals (mid-bit), shifting LSB first.
  - STOP: sample after DIV_RATE cycles.
    - Sample = 1: latch the byte into DATA and set RxDone.
    - Sample = 0 (framing error): discard the byte; flags are unchanged.
    - Either way, return to IDLE.
  - RxBusy = 1 in every state except IDLE.
- RxDone set while already 1: the new byte overwrites DATA (no overrun flag).
- Simultaneous hardware set and bus write of the same flag: hardware set wins.
- IRQRx = RxDone and IRQTx = TxDone, both registered.

## Timing
- Reset values:
  - TX = 1, RdData = 0, Rdy_ = 1, IRQRx = IRQTx = 0
  - all flags 0, Loop = 0
  - both engines idle, DATA register = 0
- Bus access is accepted at a rising edge where CS_ = 0 and As_ = 0.
  - Writes take effect at that edge.
  - Rdy_ = 0 for exactly one cycle after that edge, with RdData valid in the same cycle (read), or RdData = 0 (write).
  - RdData = 0 whenever Rdy_ = 1.
  - Back-to-back accesses are accepted on every cycle.
- TX timing:
  - A DATA write accepted at edge N drives TX = 0 from edge N.
  - The stop bit ends at edge N + 10·DIV_RATE, where TxBusy → 0 and TxDone → 1.
- RX latency: RxDone rises 2 cycles (synchroniser) + DIV_RATE/2 + 9·DIV_RATE cycles after the RX falling edge, ±1 cycle.
- Reset asserted mid-frame: TX returns to 1 immediately (asynchronously); any partial RX byte is lost.
- The bit counter wraps only via state transitions. The divider counter reloads at every bit boundary.

## Configuration
- UART_LOOPBACK_EN:
  - Defined: STATUS bit4 (Loop) is implemented. When Loop = 1, the receiver input is the internal TX signal instead of RX, and the TX pin is held at 1.
  - Undefined: bit4 reads 0, writes to it are ignored, and the receiver always uses RX.

## Structure
- Shared header uart.vh holds:
  - UART_ADDR_BUS and UART_ADDR_W (2)
  - register offsets UART_ADDR_STATUS = 0 and UART_ADDR_DATA = 1
  - STATUS bit positions
  - RX state encodings (2 bits)
  - UART_DIV_RATE default
- Reuse the existing WORD_DATA_BUS, RESET_EDGE, RESET_ENABLE and ENABLE_ macros.
- One sub-module, uart_rx: synchroniser plus RX state machine, with outputs rx_data[7:0], rx_end (1-cycle pulse) and rx_busy. The TX engine and bus register file stay in uart_ctrl.

## Test plan
All scenarios use DIV_RATE = 16.
- Reset → TX = 1, Rdy_ = 1, RdData = 0; a read of STATUS returns 0.
- Write DATA = 0xA5 → TX carries the bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. TxBusy = 1 throughout; TxDone = IRQTx = 1 at cycle 160. A second write at cycle 50 does not disturb the frame.
- Drive RX with a 0x3C frame → RxDone = 1, IRQRx = 1, and a read of DATA returns 0x0000003C. Writing STATUS = 0 clears IRQRx on the following cycle.
- Drive RX low for 4 cycles only (glitch), then a 0x55 frame with stop bit = 0 → RxDone stays 0 and DATA is unchanged.
- Assert reset_ at cycle 40 of a TX frame → TX = 1 immediately. After release, a new DATA write transmits normally.
- With UART_LOOPBACK_EN defined: write STATUS = 0x10, then DATA = 0x7E → RxDone = 1, DATA reads 0x7E, and the TX pin stays 1 throughout.
